pixel_run_detector: RTL and testbench

- Streaming front-end of the marker-tracking path: classifies each incoming RGB pixel as target or non-target.
- Tracks horizontal runs of target pixels on each line and emits run start/finish pulses with the run's left edge, width and line number.
- Output feeds the per-line widest-run / centre-point detection stage directly.
- Sits between the camera/VGA pixel stream and the point detector; one pixel per clock when i_valid is high.

---
 rtl/pixel_run_pkg.sv | 37 +++
 rtl/pixel_classifier.sv | 19 +
 rtl/pixel_run_detector.sv | 173 +++++++++++++++++
 tb/tb_pixel_run_detector.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_run_pkg.sv
// pixel_run_pkg: shared types and default thresholds for the pixel run detector.
// Build macro RUN_GAP_FILL_EN adds the GAP state used to bridge short gaps in a run.
package pixel_run_pkg;

    localparam int X_W = 10;
    localparam int Y_W = 9;

    localparam int         H_ACTIVE_DEF = 640;
    localparam logic [7:0] R_MIN_DEF    = 8'd160;
    localparam logic [7:0] G_MAX_DEF    = 8'd90;
    localparam logic [7:0] B_MAX_DEF    = 8'd90;
    localparam int         MIN_RUN_DEF  = 4;
    localparam int         GAP_TOL_DEF  = 2;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        RUN   = 2'd2
`ifdef RUN_GAP_FILL_EN
        ,
        GAP   = 2'd3
`endif
    } state_t;

    // Inclusive span from the run's left edge to its last target pixel.
    function automatic logic [X_W-1:0] run_width(input logic [X_W-1:0] first,
                                                 input logic [X_W-1:0] last);
        return last - first + 10'd1;
    endfunction

endpackage

// File: rtl/pixel_classifier.sv
// pixel_classifier: combinational RGB threshold test; a blanking pixel is never a target.
module pixel_classifier
    import pixel_run_pkg::*;
#(
    parameter logic [7:0] R_MIN = R_MIN_DEF,
    parameter logic [7:0] G_MAX = G_MAX_DEF,
    parameter logic [7:0] B_MAX = B_MAX_DEF
) (
    input  logic        valid,
    input  logic [23:0] rgb,
    output logic        target
);

    rgb_t px;

    assign px     = rgb;
    assign target = valid && (px.r >= R_MIN) && (px.g <= G_MAX) && (px.b <= B_MAX);

endmodule

// File: rtl/pixel_run_detector.sv
// pixel_run_detector: tracks horizontal runs of target pixels and reports each run
// once it reaches MIN_RUN pixels (o_start) and again when it ends (o_finish).
// Build macro RUN_GAP_FILL_EN: bridge up to GAP_TOL non-target pixels inside a run.
// Valid/ready: there is no back-pressure; i_valid qualifies one pixel per clock and
// the o_start/o_finish pulses are single-cycle, registered one clock after the pixel.
module pixel_run_detector
    import pixel_run_pkg::*;
#(
    parameter int         H_ACTIVE = H_ACTIVE_DEF,
    parameter logic [7:0] R_MIN    = R_MIN_DEF,
    parameter logic [7:0] G_MAX    = G_MAX_DEF,
    parameter logic [7:0] B_MAX    = B_MAX_DEF,
    parameter int         MIN_RUN  = MIN_RUN_DEF
`ifdef RUN_GAP_FILL_EN
    ,
    parameter int         GAP_TOL  = GAP_TOL_DEF
`endif
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_valid,
    input  logic [X_W-1:0] i_x,
    input  logic [Y_W-1:0] i_y,
    input  logic [23:0]    i_rgb,
    output logic           o_start,
    output logic           o_finish,
    output logic [X_W-1:0] o_left_edge,
    output logic [X_W-1:0] o_width,
    output logic [Y_W-1:0] o_y
);

    localparam logic [X_W-1:0] X_LAST  = X_W'(H_ACTIVE - 1);
    localparam logic [3:0]     MIN_LEN = 4'(MIN_RUN);

    state_t         state;
    logic           target;
    logic           line_end;
    logic [X_W-1:0] start_x;
    logic [X_W-1:0] last_x;
    logic [Y_W-1:0] run_y;
    logic [3:0]     len;
    logic [3:0]     len_next;
`ifdef RUN_GAP_FILL_EN
    logic [3:0]     gap;
    logic [3:0]     gap_next;
`endif

    pixel_classifier #(
        .R_MIN (R_MIN),
        .G_MAX (G_MAX),
        .B_MAX (B_MAX)
    ) u_classifier (
        .valid  (i_valid),
        .rgb    (i_rgb),
        .target (target)
    );

    assign line_end = i_valid && (i_x == X_LAST);
    assign len_next = len + 4'd1;
`ifdef RUN_GAP_FILL_EN
    assign gap_next = gap + 4'd1;
`endif

    // Run-tracking FSM with registered pulses and run descriptors.
    // A run reaching MIN_RUN exactly on the last pixel of a line is dropped, so a
    // start pulse is never issued in the same cycle as its own finish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            start_x     <= '0;
            last_x      <= '0;
            run_y       <= '0;
            len         <= '0;
`ifdef RUN_GAP_FILL_EN
            gap         <= '0;
`endif
            o_start     <= 1'b0;
            o_finish    <= 1'b0;
            o_left_edge <= '0;
            o_width     <= '0;
            o_y         <= '0;
        end else begin
            o_start  <= 1'b0;
            o_finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (target && !line_end) begin
                        start_x <= i_x;
                        last_x  <= i_x;
                        run_y   <= i_y;
                        len     <= 4'd1;
                        if (MIN_RUN == 1) begin
                            o_start     <= 1'b1;
                            o_left_edge <= i_x;
                            o_y         <= i_y;
                            state       <= RUN;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (target && !line_end) begin
                        last_x <= i_x;
                        if (len_next == MIN_LEN) begin
                            len         <= MIN_LEN;
                            o_start     <= 1'b1;
                            o_left_edge <= start_x;
                            o_y         <= run_y;
                            state       <= RUN;
                        end else begin
                            len <= len_next;
                        end
                    end else begin
                        len   <= '0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (target) begin
                        last_x <= i_x;
                        if (line_end) begin
                            o_finish <= 1'b1;
                            o_width  <= run_width(start_x, i_x);
                            len      <= '0;
                            state    <= IDLE;
                        end
                    end
`ifdef RUN_GAP_FILL_EN
                    else if (i_valid && !line_end && GAP_TOL > 0) begin
                        gap   <= 4'd1;
                        state <= GAP;
                    end
`endif
                    else begin
                        o_finish <= 1'b1;
                        o_width  <= run_width(start_x, last_x);
                        len      <= '0;
                        state    <= IDLE;
                    end
                end
`ifdef RUN_GAP_FILL_EN
                GAP: begin
                    if (target) begin
                        last_x <= i_x;
                        gap    <= '0;
                        if (line_end) begin
                            o_finish <= 1'b1;
                            o_width  <= run_width(start_x, i_x);
                            len      <= '0;
                            state    <= IDLE;
                        end else begin
                            state <= RUN;
                        end
                    end else if (i_valid && !line_end && int'(gap_next) <= GAP_TOL) begin
                        gap <= gap_next;
                    end else begin
                        o_finish <= 1'b1;
                        o_width  <= run_width(start_x, last_x);
                        gap      <= '0;
                        len      <= '0;
                        state    <= IDLE;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_run_detector.sv
// tb_pixel_run_detector: directed and randomized pixel streams against a run-level
// reference model; build with +define+RUN_GAP_FILL_EN to cover gap bridging.
module tb_pixel_run_detector;

    localparam int H_ACTIVE = 640;
    localparam int R_MIN    = 160;
    localparam int G_MAX    = 90;
    localparam int B_MAX    = 90;
    localparam int MIN_RUN  = 4;
`ifdef RUN_GAP_FILL_EN
    localparam int GAP_EFF  = 2;
`else
    localparam int GAP_EFF  = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic [9:0]  i_x = '0;
    logic [8:0]  i_y = '0;
    logic [23:0] i_rgb = '0;
    logic        o_start;
    logic        o_finish;
    logic [9:0]  o_left_edge;
    logic [9:0]  o_width;
    logic [8:0]  o_y;

    int n_checks = 0;
    int n_fail   = 0;

    // stimulus queues, one entry per clock
    logic        p_valid[$];
    logic [9:0]  p_x[$];
    logic [8:0]  p_y[$];
    logic [23:0] p_rgb[$];

    // expected per-cycle results from the reference model
    logic        e_st[$];
    logic        e_fi[$];
    logic [9:0]  e_left[$];
    logic [8:0]  e_y[$];
    logic [9:0]  e_w[$];

    // held expected descriptor values
    logic [9:0]  m_left;
    logic [8:0]  m_y;
    logic [9:0]  m_w;

    // observations of the current scenario
    logic [9:0]  obs_w[$];
    int          n_start_obs;
    int          n_fin_obs;
    int          n_both = 0;

    pixel_run_detector dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_x         (i_x),
        .i_y         (i_y),
        .i_rgb       (i_rgb),
        .o_start     (o_start),
        .o_finish    (o_finish),
        .o_left_edge (o_left_edge),
        .o_width     (o_width),
        .o_y         (o_y)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    function automatic bit is_target(input logic v, input logic [23:0] c);
        return v && (c[23:16] >= 8'(R_MIN)) && (c[15:8] <= 8'(G_MAX)) && (c[7:0] <= 8'(B_MAX));
    endfunction

    function automatic logic [23:0] tgt_rgb();
        logic [7:0] r, g, b;
        r = ($urandom_range(0, 3) == 0) ? 8'(R_MIN) : 8'($urandom_range(R_MIN, 255));
        g = ($urandom_range(0, 3) == 0) ? 8'(G_MAX) : 8'($urandom_range(0, G_MAX));
        b = ($urandom_range(0, 3) == 0) ? 8'(B_MAX) : 8'($urandom_range(0, B_MAX));
        return {r, g, b};
    endfunction

    function automatic logic [23:0] non_rgb();
        logic [23:0] c;
        c = tgt_rgb();
        case ($urandom_range(0, 2))
            0:       c[23:16] = ($urandom_range(0, 1) == 0) ? 8'(R_MIN - 1) : 8'($urandom_range(0, R_MIN - 1));
            1:       c[15:8]  = ($urandom_range(0, 1) == 0) ? 8'(G_MAX + 1) : 8'($urandom_range(G_MAX + 1, 255));
            default: c[7:0]   = ($urandom_range(0, 1) == 0) ? 8'(B_MAX + 1) : 8'($urandom_range(B_MAX + 1, 255));
        endcase
        return c;
    endfunction

    task automatic push_pix(input logic v, input int x, input int y, input logic [23:0] c);
        p_valid.push_back(v);
        p_x.push_back(10'(x));
        p_y.push_back(9'(y));
        p_rgb.push_back(c);
    endtask

    task automatic push_span(input int y, input int xs, input int xe, input bit tgt);
        for (int x = xs; x <= xe; x++) push_pix(1'b1, x, y, tgt ? tgt_rgb() : non_rgb());
    endtask

    // blanking cycles carry random colours, including target-looking ones
    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push_pix(1'b0, 0, 0, 24'($urandom()));
    endtask

    // Reference model: scan the stream for runs. A run is reported when its first
    // MIN_RUN pixels are consecutive targets on one line, the MIN_RUN-th not being
    // the last pixel of the line. It then extends across targets and gaps of at most
    // GAP_EFF valid non-target pixels, and closes on blanking, a longer gap, or line end.
    task automatic build_expect();
        int n, k, j, m, g, last, e;
        bit tg[$];
        bit le[$];
        n = p_x.size();
        e_st.delete(); e_fi.delete(); e_left.delete(); e_y.delete(); e_w.delete();
        for (int i = 0; i < n; i++) begin
            e_st.push_back(1'b0);
            e_fi.push_back(1'b0);
            e_left.push_back('0);
            e_y.push_back('0);
            e_w.push_back('0);
            tg.push_back(is_target(p_valid[i], p_rgb[i]));
            le.push_back(p_valid[i] && (p_x[i] == 10'(H_ACTIVE - 1)));
        end
        k = 0;
        while (k < n) begin
            if (!tg[k]) begin
                k++;
            end else begin
                j = k;
                while ((j - k + 1) < MIN_RUN && (j + 1) < n && tg[j + 1] && !le[j]) j++;
                if ((j - k + 1) < MIN_RUN || le[j]) begin
                    k = j + 1;
                end else begin
                    e_st[j]   = 1'b1;
                    e_left[j] = p_x[k];
                    e_y[j]    = p_y[k];
                    last = j;
                    m    = j + 1;
                    g    = 0;
                    e    = -1;
                    while (e < 0) begin
                        if (m >= n) e = n;
                        else if (tg[m]) begin
                            last = m;
                            g    = 0;
                            if (le[m]) e = m;
                            else m++;
                        end else if (!p_valid[m]) begin
                            e = m;
                        end else begin
                            g++;
                            if (g > GAP_EFF || le[m]) e = m;
                            else m++;
                        end
                    end
                    if (e < n) begin
                        e_fi[e] = 1'b1;
                        e_w[e]  = p_x[last] - p_x[k] + 10'd1;
                    end
                    k = e + 1;
                end
            end
        end
    endtask

    // drive the queued stream one pixel per clock and score every cycle
    task automatic run_scenario();
        build_expect();
        obs_w.delete();
        n_start_obs = 0;
        n_fin_obs   = 0;
        for (int k = 0; k < p_x.size(); k++) begin
            i_valid = p_valid[k];
            i_x     = p_x[k];
            i_y     = p_y[k];
            i_rgb   = p_rgb[k];
            @(posedge clk);
            #1;
            if (e_st[k]) begin
                m_left = e_left[k];
                m_y    = e_y[k];
            end
            if (e_fi[k]) m_w = e_w[k];
            check_val("o_start", 32'(o_start), 32'(e_st[k]));
            check_val("o_finish", 32'(o_finish), 32'(e_fi[k]));
            check_val("o_left_edge", 32'(o_left_edge), 32'(m_left));
            check_val("o_y", 32'(o_y), 32'(m_y));
            check_val("o_width", 32'(o_width), 32'(m_w));
            if (o_start) n_start_obs++;
            if (o_finish) begin
                n_fin_obs++;
                obs_w.push_back(o_width);
            end
            if (o_start && o_finish) n_both++;
        end
        i_valid = 1'b0;
        p_valid.delete(); p_x.delete(); p_y.delete(); p_rgb.delete();
    endtask

    function automatic logic [9:0] get_w(input int i);
        return (obs_w.size() > i) ? obs_w[i] : 10'h3ff;
    endfunction

    initial begin
        m_left = '0;
        m_y    = '0;
        m_w    = '0;

        // reset state
        #1 rst = 1'b1;
        #1;
        check_val("rst_start", 32'(o_start), 0);
        check_val("rst_finish", 32'(o_finish), 0);
        check_val("rst_left", 32'(o_left_edge), 0);
        check_val("rst_width", 32'(o_width), 0);
        check_val("rst_y", 32'(o_y), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // single run 100..149 on row 5
        push_span(5, 96, 99, 0);
        push_span(5, 100, 149, 1);
        push_span(5, 150, 155, 0);
        push_idle(2);
        run_scenario();
        check_val("single_starts", 32'(n_start_obs), 1);
        check_val("single_finishes", 32'(n_fin_obs), 1);
        check_val("single_width", 32'(get_w(0)), 50);
        check_val("single_left", 32'(o_left_edge), 100);
        check_val("single_y", 32'(o_y), 5);

        // three-pixel run stays below MIN_RUN
        push_span(6, 8, 9, 0);
        push_span(6, 10, 12, 1);
        push_span(6, 13, 16, 0);
        run_scenario();
        check_val("short_starts", 32'(n_start_obs), 0);
        check_val("short_finishes", 32'(n_fin_obs), 0);

        // run closed by line end, next line starts a fresh run at x=0
        push_span(7, 620, 629, 0);
        push_span(7, 630, 639, 1);
        push_span(8, 0, 14, 1);
        push_span(8, 15, 17, 0);
        push_idle(2);
        run_scenario();
        check_val("lineend_starts", 32'(n_start_obs), 2);
        check_val("lineend_width", 32'(get_w(0)), 10);
        check_val("nextline_width", 32'(get_w(1)), 15);

        // two-pixel gap inside a run
        push_span(9, 195, 199, 0);
        push_span(9, 200, 209, 1);
        push_span(9, 210, 211, 0);
        push_span(9, 212, 219, 1);
        push_span(9, 220, 225, 0);
        run_scenario();
`ifdef RUN_GAP_FILL_EN
        check_val("gap2_finishes", 32'(n_fin_obs), 1);
        check_val("gap2_width", 32'(get_w(0)), 20);
`else
        check_val("gap2_finishes", 32'(n_fin_obs), 2);
        check_val("gap2_width", 32'(get_w(0)), 10);
        check_val("gap2_width2", 32'(get_w(1)), 8);
`endif

        // three-pixel gap always splits the run
        push_span(10, 200, 209, 1);
        push_span(10, 210, 212, 0);
        push_span(10, 213, 219, 1);
        push_span(10, 220, 225, 0);
        run_scenario();
        check_val("gap3_finishes", 32'(n_fin_obs), 2);
        check_val("gap3_width", 32'(get_w(0)), 10);
        check_val("gap3_width2", 32'(get_w(1)), 7);

        // blanking ends a run that started at 280
        push_span(11, 276, 279, 0);
        push_span(11, 280, 299, 1);
        push_pix(1'b0, 300, 11, tgt_rgb());
        push_idle(2);
        run_scenario();
        check_val("blank_width", 32'(get_w(0)), 20);

        // reset in the middle of a reported run
        push_span(12, 96, 99, 0);
        push_span(12, 100, 119, 1);
        run_scenario();
        check_val("pre_rst_left", 32'(o_left_edge), 100);
        i_valid = 1'b1;
        i_x     = 10'd120;
        i_y     = 9'd12;
        i_rgb   = tgt_rgb();
        #2 rst = 1'b1;
        #1;
        check_val("mid_rst_start", 32'(o_start), 0);
        check_val("mid_rst_finish", 32'(o_finish), 0);
        check_val("mid_rst_left", 32'(o_left_edge), 0);
        check_val("mid_rst_width", 32'(o_width), 0);
        check_val("mid_rst_y", 32'(o_y), 0);
        @(negedge clk);
        i_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_left = '0;
        m_y    = '0;
        m_w    = '0;
        push_idle(4);
        run_scenario();
        check_val("post_rst_finishes", 32'(n_fin_obs), 0);

        // next run after reset is reported normally
        push_span(13, 50, 70, 1);
        push_span(13, 71, 73, 0);
        run_scenario();
        check_val("after_rst_starts", 32'(n_start_obs), 1);
        check_val("after_rst_width", 32'(get_w(0)), 21);

        // randomized lines ending at the line boundary
        for (int l = 0; l < 10; l++) begin
            int x, kind, len;
            x = $urandom_range(560, 610);
            while (x < H_ACTIVE) begin
                kind = $urandom_range(0, 9);
                len  = (kind < 6) ? $urandom_range(1, 12) : $urandom_range(1, 4);
                for (int i = 0; i < len && x < H_ACTIVE; i++) begin
                    if (kind < 6) push_pix(1'b1, x, 20 + l, tgt_rgb());
                    else if (kind < 9) push_pix(1'b1, x, 20 + l, non_rgb());
                    else push_pix(1'b0, x, 20 + l, 24'($urandom()));
                    x++;
                end
            end
            push_idle($urandom_range(0, 2));
        end
        push_idle(3);
        run_scenario();

        check_val("start_finish_coincide", 32'(n_both), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
